// File: rtl/run_trace_pkg.sv
// run_trace_pkg: shared FSM encoding and helper functions for run_trace_ctrl.
// Optional feature macro used by the design: TRACE_ALU_EN.
package run_trace_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Ceiling log2 for sizing counters and addresses; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Signature step: rotate sig left by one within w bits, then xor in data.
  // Operates on a 64-bit carrier so it serves any WIDTH up to 64.
  function automatic logic [63:0] rot_xor(input logic [63:0] sig,
                                          input logic [63:0] data,
                                          input int          w);
    logic [63:0] mask;
    logic [63:0] rot;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    rot  = ((sig << 1) | (sig >> (w - 1))) & mask;
    return rot ^ (data & mask);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: DEPTH x WIDTH storage with one synchronous write port and one
// registered read port. A same-cycle read of the written address returns the old word.
module trace_ram
  import run_trace_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, cleared by reset so the output starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o <= '0;
    end else begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/run_trace_ctrl.sv
// run_trace_ctrl: holds the processor in start_up, releases it for one bounded run,
// ends the run on HALT_WORD or after MAX_CYCLES, and captures a circular trace of
// busW together with a rolling signature.
// Optional feature macro: TRACE_ALU_EN (also trace aluresult and mix it into the signature).
module run_trace_ctrl
  import run_trace_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 16,
  parameter int               MAX_CYCLES   = 64,
  parameter int               RESET_CYCLES = 1,
  parameter logic [WIDTH-1:0] HALT_WORD    = {WIDTH{1'b1}}
) (
  input  logic                            clk,
  input  logic                            start_up,
  input  logic                            go,
  output logic                            cpu_start_up,
  input  logic [WIDTH-1:0]                instruction,
  input  logic [WIDTH-1:0]                busW,
  input  logic [WIDTH-1:0]                aluresult,
  output logic                            busy,
  output logic                            done,
  output logic                            halted,
  output logic [clog2(MAX_CYCLES+1)-1:0]  cycle_count,
  output logic [clog2(DEPTH):0]           trace_count,
  input  logic [clog2(DEPTH)-1:0]         trace_rd_addr,
  output logic [WIDTH-1:0]                trace_rd_data,
  output logic [WIDTH-1:0]                trace_rd_alu,
  output logic [WIDTH-1:0]                signature
);

  localparam int AW  = clog2(DEPTH);
  localparam int TCW = AW + 1;
  localparam int CW  = clog2(MAX_CYCLES + 1);
  localparam int RW  = clog2(RESET_CYCLES + 1);

  state_e           state_q, state_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [TCW-1:0]   tc_q, tc_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic             halted_q, halted_d;
  logic             rd_valid_q;

  logic             rst_last_s;
  logic             halt_hit_s;
  logic             timeout_s;
  logic             trace_we_s;
  logic [CW-1:0]    cyc_inc_s;
  logic [WIDTH-1:0] sig_mix_s;
  logic [63:0]      sig_wide_s;
  logic [WIDTH-1:0] sig_next_s;
  logic [AW-1:0]    rd_phys_s;
  logic             rd_hit_s;
  logic [WIDTH-1:0] busw_rdata_s;

  assign rst_last_s = (rst_cnt_q == RW'(RESET_CYCLES - 1));
  assign halt_hit_s = (instruction == HALT_WORD);
  assign cyc_inc_s  = cyc_q + CW'(1);
  assign timeout_s  = (cyc_inc_s == CW'(MAX_CYCLES));

`ifdef TRACE_ALU_EN
  assign sig_mix_s = busW ^ aluresult;
`else
  assign sig_mix_s = busW;
`endif
  assign sig_wide_s = rot_xor(64'(sig_q), 64'(sig_mix_s), WIDTH);
  assign sig_next_s = sig_wide_s[WIDTH-1:0];

  // Logical read address 0 maps to the oldest valid entry behind the write pointer.
  assign rd_phys_s = wr_ptr_q - tc_q[AW-1:0] + trace_rd_addr;
  assign rd_hit_s  = ({1'b0, trace_rd_addr} < tc_q);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (start_up) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; halt and timeout both finish a run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) state_d = S_RESET;
        else    state_d = state_q;
      end
      S_RESET: begin
        if (rst_last_s) state_d = S_RUN;
        else            state_d = S_RESET;
      end
      S_RUN: begin
        if (halt_hit_s || timeout_s) state_d = S_DONE;
        else                         state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM output decode: processor is released only while running.
  always_comb begin
    cpu_start_up = 1'b1;
    busy         = 1'b0;
    done         = 1'b0;
    trace_we_s   = 1'b0;
    case (state_q)
      S_IDLE:  cpu_start_up = 1'b1;
      S_RESET: busy = 1'b1;
      S_RUN: begin
        cpu_start_up = 1'b0;
        busy         = 1'b1;
        trace_we_s   = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: cpu_start_up = 1'b1;
    endcase
  end

  // Counter, pointer and signature next values; go clears results, RUN advances them.
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    cyc_d     = cyc_q;
    tc_d      = tc_q;
    wr_ptr_d  = wr_ptr_q;
    sig_d     = sig_q;
    halted_d  = halted_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          rst_cnt_d = '0;
          cyc_d     = '0;
          tc_d      = '0;
          wr_ptr_d  = '0;
          sig_d     = '0;
          halted_d  = 1'b0;
        end else begin
          halted_d  = halted_q;
        end
      end
      S_RESET: begin
        if (rst_last_s) rst_cnt_d = '0;
        else            rst_cnt_d = rst_cnt_q + RW'(1);
      end
      S_RUN: begin
        cyc_d    = cyc_inc_s;
        tc_d     = (tc_q == TCW'(DEPTH)) ? tc_q : tc_q + TCW'(1);
        wr_ptr_d = wr_ptr_q + AW'(1);
        sig_d    = sig_next_s;
        if (halt_hit_s) halted_d = 1'b1;
        else            halted_d = halted_q;
      end
      default: rst_cnt_d = '0;
    endcase
  end

  // Run result registers.
  always_ff @(posedge clk) begin
    if (start_up) begin
      rst_cnt_q  <= '0;
      cyc_q      <= '0;
      tc_q       <= '0;
      wr_ptr_q   <= '0;
      sig_q      <= '0;
      halted_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rst_cnt_q  <= rst_cnt_d;
      cyc_q      <= cyc_d;
      tc_q       <= tc_d;
      wr_ptr_q   <= wr_ptr_d;
      sig_q      <= sig_d;
      halted_q   <= halted_d;
      rd_valid_q <= rd_hit_s;
    end
  end

  trace_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_trace_busw (
    .clk     (clk),
    .rst     (start_up),
    .we_i    (trace_we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (busW),
    .raddr_i (rd_phys_s),
    .rdata_o (busw_rdata_s)
  );

`ifdef TRACE_ALU_EN
  logic [WIDTH-1:0] alu_rdata_s;

  trace_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_trace_alu (
    .clk     (clk),
    .rst     (start_up),
    .we_i    (trace_we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (aluresult),
    .raddr_i (rd_phys_s),
    .rdata_o (alu_rdata_s)
  );

  assign trace_rd_alu = rd_valid_q ? alu_rdata_s : '0;
`else
  // aluresult is not traced in this build; the port reads as constant zero.
  assign trace_rd_alu = aluresult & {WIDTH{1'b0}};
`endif

  assign trace_rd_data = rd_valid_q ? busw_rdata_s : '0;
  assign halted        = halted_q;
  assign cycle_count   = cyc_q;
  assign trace_count   = tc_q;
  assign signature     = sig_q;

endmodule

// File: tb/tb_run_trace_ctrl.sv
// tb_run_trace_ctrl: scenario tasks against a queue-based reference of the run history.
module tb_run_trace_ctrl;

  localparam int W  = 32;
  localparam int D  = 4;
  localparam int MC = 8;
  localparam int RC = 2;
  localparam logic [W-1:0] HALT = 32'hFFFF_FFFF;

  logic         clk = 1'b0;
  logic         start_up, go, cpu_start_up;
  logic [W-1:0] instruction, busW, aluresult;
  logic         busy, done, halted;
  logic [3:0]   cycle_count;
  logic [2:0]   trace_count;
  logic [1:0]   trace_rd_addr;
  logic [W-1:0] trace_rd_data, trace_rd_alu, signature;

  int errors = 0;
  int checks = 0;
  int busy_seen;
  bit exp_halted;
  logic [W-1:0] q[$];
  logic [W-1:0] qa[$];

  always #5 clk = ~clk;

  run_trace_ctrl #(.WIDTH(W), .DEPTH(D), .MAX_CYCLES(MC), .RESET_CYCLES(RC), .HALT_WORD(HALT)) dut (
    .clk(clk), .start_up(start_up), .go(go), .cpu_start_up(cpu_start_up),
    .instruction(instruction), .busW(busW), .aluresult(aluresult),
    .busy(busy), .done(done), .halted(halted), .cycle_count(cycle_count),
    .trace_count(trace_count), .trace_rd_addr(trace_rd_addr),
    .trace_rd_data(trace_rd_data), .trace_rd_alu(trace_rd_alu), .signature(signature)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the run is the list of recorded words; the trace keeps the newest D.
  function automatic int model_tc();
    return (q.size() < D) ? q.size() : D;
  endfunction

  function automatic logic [W-1:0] model_entry(int k, bit alu);
    int tc = model_tc();
    if (k >= tc) return '0;
    return alu ? qa[q.size() - tc + k] : q[q.size() - tc + k];
  endfunction

  function automatic logic [W-1:0] model_sig();
    logic [W-1:0] s = '0;
    foreach (q[i]) begin
      s = {s[W-2:0], s[W-1]} ^ q[i];
`ifdef TRACE_ALU_EN
      s = s ^ qa[i];
`endif
    end
    return s;
  endfunction

  // Stimulus only: go, RESET phase, then n RUN cycles (halt on the last one if requested).
  task automatic do_run(input int n, input bit halt, input bit rnd, input logic [W-1:0] base, input int go_at);
    busy_seen = 0;
    go = 1'b1; tick(); go = 1'b0;
    if (busy) busy_seen++;
    repeat (RC) begin tick(); if (busy) busy_seen++; end
    q.delete(); qa.delete();
    for (int i = 0; i < n; i++) begin
      busW        = rnd ? $urandom : base + W'(i);
      aluresult   = rnd ? $urandom : busW + 32'd100;
      instruction = (halt && i == n - 1) ? HALT : ($urandom & 32'h7FFF_FFFF);
      go          = (i == go_at);
      q.push_back(busW); qa.push_back(aluresult);
      tick();
      if (busy) busy_seen++;
    end
    go = 1'b0; instruction = '0;
    exp_halted = halt;
  endtask

  task automatic test_reset();
    start_up = 1'b1; tick(); tick();
    q.delete(); qa.delete();
    checks++; if (cpu_start_up !== 1'b1) begin errors++; $display("FAIL reset_cpu_start_up got %0b want 1", cpu_start_up); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", halted); end
    checks++; if (cycle_count !== 4'd0) begin errors++; $display("FAIL reset_cycle_count got %0d want 0", cycle_count); end
    checks++; if (trace_count !== 3'd0) begin errors++; $display("FAIL reset_trace_count got %0d want 0", trace_count); end
    checks++; if (signature !== 32'd0) begin errors++; $display("FAIL reset_signature got %0h want 0", signature); end
    checks++; if (trace_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data got %0h want 0", trace_rd_data); end
    start_up = 1'b0; tick();
    checks++; if (cpu_start_up !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL idle_hold got cpu=%0b busy=%0b want 1/0", cpu_start_up, busy); end
  endtask

  task automatic test_halt();
    do_run(6, 1'b1, 1'b0, 32'd1, -1);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || cpu_start_up !== 1'b1) begin errors++; $display("FAIL halt_flags got done=%0b busy=%0b cpu=%0b want 1/0/1", done, busy, cpu_start_up); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %0b want 1", halted); end
    checks++; if (cycle_count !== 4'd6) begin errors++; $display("FAIL halt_cycle_count got %0d want 6", cycle_count); end
    checks++; if (trace_count !== 3'(model_tc())) begin errors++; $display("FAIL halt_trace_count got %0d want %0d", trace_count, model_tc()); end
    checks++; if (signature !== model_sig()) begin errors++; $display("FAIL halt_signature got %0h want %0h", signature, model_sig()); end
    for (int k = 0; k < D; k++) begin
      trace_rd_addr = 2'(k); tick();
      checks++; if (trace_rd_data !== model_entry(k, 1'b0)) begin errors++; $display("FAIL halt_read[%0d] got %0h want %0h", k, trace_rd_data, model_entry(k, 1'b0)); end
    end
    repeat (3) tick();
    checks++; if (done !== 1'b1 || cycle_count !== 4'd6 || signature !== model_sig()) begin errors++; $display("FAIL done_stable got done=%0b cyc=%0d sig=%0h want 1/6/%0h", done, cycle_count, signature, model_sig()); end
  endtask

  task automatic test_short_read();
    do_run(2, 1'b1, 1'b0, 32'h50, -1);
    checks++; if (trace_count !== 3'd2) begin errors++; $display("FAIL short_trace_count got %0d want 2", trace_count); end
    for (int k = 0; k < D; k++) begin
      trace_rd_addr = 2'(k); tick();
      checks++; if (trace_rd_data !== model_entry(k, 1'b0)) begin errors++; $display("FAIL short_read[%0d] got %0h want %0h", k, trace_rd_data, model_entry(k, 1'b0)); end
    end
  endtask

  task automatic test_timeout();
    do_run(MC, 1'b0, 1'b1, 32'd0, -1);
    checks++; if (done !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL timeout_flags got done=%0b halted=%0b want 1/0", done, halted); end
    checks++; if (cycle_count !== 4'(MC)) begin errors++; $display("FAIL timeout_cycle_count got %0d want %0d", cycle_count, MC); end
    checks++; if (busy_seen !== RC + MC) begin errors++; $display("FAIL timeout_busy_cycles got %0d want %0d", busy_seen, RC + MC); end
    checks++; if (signature !== model_sig()) begin errors++; $display("FAIL timeout_signature got %0h want %0h", signature, model_sig()); end
    repeat (2) tick();
    checks++; if (cycle_count !== 4'(MC) || done !== 1'b1) begin errors++; $display("FAIL timeout_stable got cyc=%0d done=%0b want %0d/1", cycle_count, done, MC); end
  endtask

  task automatic test_wrap();
    do_run(7, 1'b1, 1'b0, 32'd10, -1);
    checks++; if (trace_count !== 3'd4) begin errors++; $display("FAIL wrap_trace_count got %0d want 4", trace_count); end
    for (int k = 0; k < D; k++) begin
      trace_rd_addr = 2'(k); tick();
      checks++; if (trace_rd_data !== model_entry(k, 1'b0)) begin errors++; $display("FAIL wrap_read[%0d] got %0h want %0h", k, trace_rd_data, model_entry(k, 1'b0)); end
    end
  endtask

  task automatic test_halt_at_timeout();
    do_run(MC, 1'b1, 1'b1, 32'd0, -1);
    checks++; if (halted !== 1'b1 || cycle_count !== 4'(MC)) begin errors++; $display("FAIL halt_wins got halted=%0b cyc=%0d want 1/%0d", halted, cycle_count, MC); end
  endtask

  task automatic test_abort();
    go = 1'b1; tick(); go = 1'b0;
    repeat (RC) tick();
    repeat (3) begin busW = $urandom; instruction = 32'd0; tick(); end
    checks++; if (busy !== 1'b1 || cpu_start_up !== 1'b0) begin errors++; $display("FAIL abort_running got busy=%0b cpu=%0b want 1/0", busy, cpu_start_up); end
    start_up = 1'b1; tick(); start_up = 1'b0;
    q.delete(); qa.delete();
    checks++; if (cpu_start_up !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL abort_flags got cpu=%0b busy=%0b done=%0b halted=%0b want 1/0/0/0", cpu_start_up, busy, done, halted); end
    checks++; if (cycle_count !== 4'd0 || trace_count !== 3'd0 || signature !== 32'd0 || trace_rd_data !== 32'd0) begin errors++; $display("FAIL abort_values got cyc=%0d tc=%0d sig=%0h rd=%0h want 0", cycle_count, trace_count, signature, trace_rd_data); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_idle got busy=%0b done=%0b want 0/0", busy, done); end
  endtask

  task automatic test_go_in_run_and_restart();
    do_run(5, 1'b1, 1'b0, 32'd200, 2);
    checks++; if (cycle_count !== 4'd5 || halted !== 1'b1 || signature !== model_sig()) begin errors++; $display("FAIL go_in_run got cyc=%0d halted=%0b sig=%0h want 5/1/%0h", cycle_count, halted, signature, model_sig()); end
    go = 1'b1; tick(); go = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || halted !== 1'b0 || cpu_start_up !== 1'b1) begin errors++; $display("FAIL restart_flags got busy=%0b done=%0b halted=%0b cpu=%0b want 1/0/0/1", busy, done, halted, cpu_start_up); end
    checks++; if (cycle_count !== 4'd0 || trace_count !== 3'd0 || signature !== 32'd0) begin errors++; $display("FAIL restart_cleared got cyc=%0d tc=%0d sig=%0h want 0", cycle_count, trace_count, signature); end
    repeat (RC) tick();
    q.delete(); qa.delete();
    busW = 32'h1234_5678; aluresult = busW + 32'd100; instruction = HALT;
    q.push_back(busW); qa.push_back(aluresult);
    tick(); instruction = '0;
    trace_rd_addr = 2'd0; tick();
    checks++; if (cycle_count !== 4'd1 || trace_count !== 3'd1 || signature !== model_sig()) begin errors++; $display("FAIL restart_run got cyc=%0d tc=%0d sig=%0h want 1/1/%0h", cycle_count, trace_count, signature, model_sig()); end
    checks++; if (trace_rd_data !== model_entry(0, 1'b0)) begin errors++; $display("FAIL restart_read got %0h want %0h", trace_rd_data, model_entry(0, 1'b0)); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int n;
      bit h;
      n = $urandom_range(1, MC);
      h = (n < MC) ? 1'b1 : 1'($urandom_range(0, 1));
      do_run(n, h, 1'b1, 32'd0, -1);
      checks++; if (done !== 1'b1 || halted !== exp_halted) begin errors++; $display("FAIL rand%0d_flags got done=%0b halted=%0b want 1/%0b", it, done, halted, exp_halted); end
      checks++; if (cycle_count !== 4'(n) || trace_count !== 3'(model_tc())) begin errors++; $display("FAIL rand%0d_counts got cyc=%0d tc=%0d want %0d/%0d", it, cycle_count, trace_count, n, model_tc()); end
      checks++; if (signature !== model_sig()) begin errors++; $display("FAIL rand%0d_signature got %0h want %0h", it, signature, model_sig()); end
      for (int r = 0; r < 3; r++) begin
        int k;
        k = $urandom_range(0, D - 1);
        trace_rd_addr = 2'(k); tick();
        checks++; if (trace_rd_data !== model_entry(k, 1'b0)) begin errors++; $display("FAIL rand%0d_read[%0d] got %0h want %0h", it, k, trace_rd_data, model_entry(k, 1'b0)); end
      end
    end
  endtask

  task automatic test_alu();
    logic [W-1:0] exp_alu;
    do_run(5, 1'b1, 1'b0, 32'h300, -1);
    for (int k = 0; k < D; k++) begin
      trace_rd_addr = 2'(k); tick();
`ifdef TRACE_ALU_EN
      exp_alu = model_entry(k, 1'b1);
`else
      exp_alu = '0;
`endif
      checks++; if (trace_rd_alu !== exp_alu) begin errors++; $display("FAIL alu_read[%0d] got %0h want %0h", k, trace_rd_alu, exp_alu); end
    end
    checks++; if (signature !== model_sig()) begin errors++; $display("FAIL alu_signature got %0h want %0h", signature, model_sig()); end
  endtask

  initial begin
    start_up = 1'b1; go = 1'b0; instruction = '0; busW = '0; aluresult = '0; trace_rd_addr = '0;
    test_reset();
    test_halt();
    test_short_read();
    test_timeout();
    test_wrap();
    test_halt_at_timeout();
    test_abort();
    test_go_in_run_and_restart();
    test_random();
    test_alu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
